fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the opcode decoder/controller.
- Holds the PC and issues word requests to a variable-latency instruction memory (req/rdy handshake).
- Presents one 16-bit instruction per cycle to decode with a valid flag, honouring decode stalls and branch/jump redirects.
- Stops fetching after a halt opcode (instr[15:12] == HALT_OP).

Parameters:
RESET_PC  16'h0000  PC value loaded on reset
HALT_OP   4'hF      opcode field value that stops fetching

Ports:
clk          input   1   system clock, rising edge
rst_n        input   1   asynchronous active-low reset
imem_req     output  1   instruction memory request
imem_addr    output  16  byte address of request (bit 0 always 0)
imem_rdy     input   1   memory returns imem_data this cycle (qualified by imem_req)
imem_data    input   16  fetched instruction word
stall        input   1   decode cannot accept; hold instr/instr_valid
redirect     input   1   branch/jump taken; flush and refetch
redirect_pc  input   16  target address (bit 0 ignored)
instr        output  16  instruction to decoder
instr_valid  output  1   instr is live; decoder gates RegWrite/MemWrite/MemRead with it
pc_out       output  16  address of instr
pc_plus2     output  16  pc_out + 2, for link/branch-offset use
halted       output  1   1 while in HALT state

Behaviour:
- Async reset (rst_n low), values held until first clk edge after deassert:
  - pc = RESET_PC; state = RUN; instr = 16'h0000; instr_valid = 0; pc_out = RESET_PC; skid empty; imem_req = 0; halted = 0.
- slot_free = !instr_valid | !stall.
- Output register updates only when slot_free; while stall=1 and instr_valid=1, instr/pc_out/instr_valid are frozen.
- RUN:
  - imem_req = slot_free, or = 1 if a request is already outstanding; imem_addr = pc.
  - Once raised, imem_req and imem_addr are held stable until imem_rdy, regardless of stall.
  - On imem_req & imem_rdy, if slot_free: instr <= imem_data, pc_out <= pc, instr_valid <= 1, pc <= pc + 2.
  - On imem_req & imem_rdy, if !slot_free (stall rose mid-request): data and address go to the skid register, pc <= pc + 2, next = SKID.
  - If slot_free and no data arrives, instr_valid <= 0. Bubble: instr_valid drops for one cycle after a consumed instruction with no return.
  - Captured opcode == HALT_OP: next = HALT, no further requests. The halt instruction itself is still presented valid.
- SKID:
  - imem_req = 0.
  - When stall = 0: instr/pc_out <= skid contents, instr_valid <= 1, skid emptied, next = RUN (or HALT if skid opcode == HALT_OP).
- HALT:
  - imem_req = 0; halted = 1.
  - Remaining instr is consumed normally, then instr_valid <= 0.
  - Exit only by redirect or reset.
- DRAIN:
  - Entered on a redirect while a request is outstanding without rdy.
  - imem_req stays 1 at the old address until imem_rdy; the returned data is discarded, then next = RUN fetching the new pc.
- Redirect (highest priority, any state, ignores stall):
  - pc <= {redirect_pc[15:1], 1'b0}; instr_valid <= 0; skid cleared; halted cleared.
  - Request outstanding with no rdy that cycle -> DRAIN. rdy in the same cycle -> data discarded, next = RUN.
  - A second redirect during DRAIN overwrites pc; remain in DRAIN.
- Arithmetic:
  - pc + 2 is modulo 2^16 (16'hFFFE -> 16'h0000).
  - pc_plus2 = pc_out + 2, combinational, also modulo 2^16.
- Reset asserted mid-request: everything returns to reset values immediately; the pending memory response is ignored.

Test Plan:
- Reset, then imem_rdy tied 1, memory at 0x0000..0x0006 = 0x1234, 0x2345, 0x3456, 0x4567 -> instr sequence matches, with pc_out 0x0000, 0x0002, 0x0004, 0x0006, instr_valid continuously 1 from cycle 2.
- 3-cycle memory latency -> imem_addr stable while imem_req high; instr_valid pulses once per 3 cycles; no address skipped.
- stall=1 for 4 cycles while a request is outstanding, rdy arrives during the stall -> instr unchanged through the stall, skid word appears on the first cycle after stall=0, no word lost or duplicated.
- redirect to 0x0101 during an outstanding 3-cycle request -> DRAIN discards the old word, next imem_addr = 0x0100, instr_valid = 0 until the 0x0100 word arrives.
- Word 0xF000 at 0x0008 -> presented valid once; halted = 1; imem_req stays 0 for 20 cycles; later redirect to 0x0020 clears halted and fetches 0x0020.
- PC = 0xFFFE fetch -> next imem_addr = 0x0000; reset pulsed mid-stall -> instr_valid = 0 and pc_out = RESET_PC asynchronously.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to a variable-latency
// instruction memory and feeds one instruction per cycle to decode.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus2,
    output logic        halted
);

    typedef enum logic [1:0] {RUN, SKID, HALT, DRAIN} state_e;

    state_e      state_q;
    logic [15:0] pc_q, addr_q, instr_q, pc_out_q, skid_data_q, skid_pc_q;
    logic        vld_q, req_q, halted_q;

    logic        slot_free, xfer;
    logic [15:0] pc_inc, redir_pc;
    logic        unused_redir_bit;

    assign slot_free        = !vld_q || !stall;
    assign xfer             = req_q && imem_rdy;
    assign pc_inc           = pc_q + 16'd2;
    assign redir_pc         = {redirect_pc[15:1], 1'b0};
    assign unused_redir_bit = redirect_pc[0];

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_valid = vld_q;
    assign pc_out      = pc_out_q;
    assign pc_plus2    = pc_out_q + 16'd2;
    assign halted      = halted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            instr_q     <= 16'h0000;
            pc_out_q    <= RESET_PC;
            skid_data_q <= 16'h0000;
            skid_pc_q   <= RESET_PC;
            vld_q       <= 1'b0;
            req_q       <= 1'b0;
            halted_q    <= 1'b0;
        end else if (redirect) begin
            // An unanswered request must still complete on the bus, so its address is kept.
            pc_q     <= redir_pc;
            vld_q    <= 1'b0;
            halted_q <= 1'b0;
            if (req_q && !imem_rdy) begin
                state_q <= DRAIN;
            end else begin
                state_q <= RUN;
                req_q   <= 1'b1;
                addr_q  <= redir_pc;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (xfer && slot_free) begin
                        instr_q  <= imem_data;
                        pc_out_q <= pc_q;
                        vld_q    <= 1'b1;
                        pc_q     <= pc_inc;
                        if (imem_data[15:12] == HALT_OP) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                            req_q    <= 1'b0;
                        end else begin
                            req_q  <= 1'b1;
                            addr_q <= pc_inc;
                        end
                    end else if (xfer) begin
                        skid_data_q <= imem_data;
                        skid_pc_q   <= pc_q;
                        pc_q        <= pc_inc;
                        state_q     <= SKID;
                        req_q       <= 1'b0;
                    end else if (slot_free) begin
                        vld_q <= 1'b0;
                        if (!req_q) begin
                            req_q  <= 1'b1;
                            addr_q <= pc_q;
                        end
                    end
                end
                SKID: begin
                    if (!stall) begin
                        instr_q  <= skid_data_q;
                        pc_out_q <= skid_pc_q;
                        vld_q    <= 1'b1;
                        if (skid_data_q[15:12] == HALT_OP) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            req_q   <= 1'b1;
                            addr_q  <= pc_q;
                        end
                    end
                end
                HALT: begin
                    if (slot_free) vld_q <= 1'b0;
                end
                DRAIN: begin
                    if (imem_rdy) begin
                        state_q <= RUN;
                        addr_q  <= pc_q;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a memory responder with configurable latency,
// a consumption monitor checked against the sequential-fetch model, and directed scenarios.
module tb_fetch_unit;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        imem_req, imem_rdy = 1'b0;
    logic [15:0] imem_addr, imem_data;
    logic        stall = 1'b0, redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] instr, pc_out, pc_plus2;
    logic        instr_valid, halted;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h0000), .HALT_OP(4'hF)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr(instr), .instr_valid(instr_valid),
        .pc_out(pc_out), .pc_plus2(pc_plus2), .halted(halted)
    );

    logic [15:0] mem [0:32767];
    assign imem_data = mem[imem_addr[15:1]];

    int checks = 0, errors = 0;
    int lat_cfg = 1;   // 0 = random 1..4 cycles per request

    typedef struct { logic [15:0] pc; logic [15:0] data; } exp_t;
    exp_t exp_q[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: after reset/redirect the decoder sees consecutive words from the target, up to and including a halt.
    function automatic void load_expect(logic [15:0] start);
        logic [15:0] a;
        a = start;
        exp_q.delete();
        for (int i = 0; i < 4096; i++) begin
            exp_q.push_back('{a, mem[a[15:1]]});
            if (mem[a[15:1]][15:12] == 4'hF) break;
            a = a + 16'd2;
        end
    endfunction

    task automatic do_redirect(logic [15:0] tgt);
        logic [15:0] t;
        t = {tgt[15:1], 1'b0};
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = tgt;
        @(negedge clk); #1;
        load_expect(t);
        @(posedge clk); #1;
        redirect = 1'b0;
    endtask

    task automatic wait_hs(string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (imem_req && imem_rdy) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s: no handshake within 60 cycles", name);
        end
    endtask

    // Memory responder: rdy asserted once a request has been up for the chosen latency.
    initial begin
        int cnt, lat;
        logic hs;
        cnt = 0; lat = 1;
        forever begin
            @(negedge clk);
            hs = imem_req && imem_rdy;
            @(posedge clk); #1;
            if (!rst_n) begin
                cnt = 0; imem_rdy = 1'b0;
            end else begin
                if (hs) begin
                    cnt = 0;
                    lat = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
                end
                if (imem_req) cnt++; else cnt = 0;
                if (!imem_req) lat = (lat_cfg == 0) ? lat : lat_cfg;
                imem_rdy = imem_req && (cnt >= lat);
            end
        end
    end

    // Monitor: scoreboard on consumption plus stall-freeze and request-hold rules.
    initial begin
        logic pv, ps, preq, prdy, predir;
        logic [15:0] pi, pp, paddr, p2;
        exp_t e;
        pv = 0; ps = 0; preq = 0; prdy = 0; predir = 0; pi = 0; pp = 0; paddr = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pv && ps && !predir) begin
                    chk("freeze_valid", instr_valid, 1);
                    chk("freeze_instr", instr, pi);
                    chk("freeze_pc", pc_out, pp);
                end
                if (preq && !prdy) begin
                    chk("req_hold", imem_req, 1);
                    chk("addr_hold", imem_addr, paddr);
                end
                if (imem_req) chk("addr_even", imem_addr[0], 0);
                if (instr_valid && !stall) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_instr: got pc %h instr %h, none expected", pc_out, instr);
                    end else begin
                        e = exp_q.pop_front();
                        p2 = e.pc + 16'd2;
                        chk("pc_out", pc_out, e.pc);
                        chk("instr", instr, e.data);
                        chk("pc_plus2", pc_plus2, p2);
                    end
                end
            end
            pv = instr_valid; ps = stall; pi = instr; pp = pc_out;
            preq = imem_req; prdy = imem_rdy; paddr = imem_addr; predir = redirect;
        end
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom_range(0, 16'hEFFF));
        mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'h3456; mem[3] = 16'h4567;
        mem[4] = 16'hF000;

        // Reset values
        #12;
        chk("rst_valid", instr_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc_out", pc_out, 16'h0000);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_pc_plus2", pc_plus2, 16'h0002);
        load_expect(16'h0000);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Zero-wait memory: valid back-to-back from the second edge, then halt
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("stream_valid", instr_valid, (k >= 2 && k <= 6) ? 1 : 0);
        end
        chk("halted_set", halted, 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("halt_no_req", imem_req, 0);
        end
        chk("halted_hold", halted, 1);
        do_redirect(16'h0020);
        @(negedge clk);
        chk("halted_clear", halted, 0);
        repeat (6) @(posedge clk);

        // 3-cycle latency, then stall across a pending return to force the skid path
        lat_cfg = 3;
        repeat (15) @(posedge clk);
        wait_hs("skid_setup");
        @(posedge clk); #1;
        stall = 1'b1;
        repeat (4) @(posedge clk);
        #1 stall = 1'b0;
        repeat (12) @(posedge clk);

        // Redirect while a 3-cycle request is outstanding
        wait_hs("drain_setup");
        do_redirect(16'h0101);
        chk("drain_valid", instr_valid, 0);
        wait_hs("drain_done");
        chk("drain_vld_low", instr_valid, 0);
        @(negedge clk);
        chk("drain_new_addr", imem_addr, 16'h0100);
        chk("drain_new_req", imem_req, 1);
        repeat (10) @(posedge clk);

        // PC wrap
        lat_cfg = 1;
        do_redirect(16'hFFFE);
        wait_hs("wrap_hs");
        @(negedge clk);
        chk("wrap_addr", imem_addr, 16'h0000);
        repeat (5) @(posedge clk);

        // Randomized stalls, latencies and redirects
        lat_cfg = 0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 59) == 0) do_redirect(16'($urandom_range(0, 16'hFFFF)));
        end

        // Asynchronous reset during a stall
        @(posedge clk); #1;
        stall = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", instr_valid, 0);
        chk("async_rst_pc_out", pc_out, 16'h0000);
        chk("async_rst_req", imem_req, 0);
        chk("async_rst_halted", halted, 0);
        stall = 1'b0;
        load_expect(16'h0000);
        @(negedge clk); #1;
        rst_n = 1'b1;
        lat_cfg = 2;
        repeat (30) @(posedge clk);
        chk("post_rst_halted", halted, 1);
        chk("post_rst_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
